pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the line-synchronous PWM generator. It measures the width of the PWM pulse on pwm_in within each hsync-delimited period and recovers the DWIDTH-bit code that produced it.
- Sits on the loopback/readback path. Gives the bench and system a decoded value stream for checking the PWM output chain.
- Runs entirely in the clk domain. pwm_in is asynchronous and is resynchronised internally.

Parameters:
- DWIDTH, 8, width of recovered code; width counter saturates at 2^DWIDTH-1
- SYNC_STAGES, 2, flops in the pwm_in synchroniser; legal range 2..3
- TIMEOUT, 1024, clk cycles without an hsync rise before the period is declared lost; must be > 2^DWIDTH

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous active-high reset
- hsync  input  1  period-start marker, synchronous to clk; a period starts on each 0->1 transition
- pwm_in  input  1  PWM waveform under measurement, asynchronous
- data_out  output  DWIDTH  recovered pulse width of the last completed period, in clk cycles
- data_valid  output  1  one-cycle strobe; data_out and the err_* flags are valid while it is high
- err_multi  output  1  with data_valid: more than one pulse was seen in the period
- err_trunc  output  1  with data_valid: pwm_s was still high at the period end
- err_sat  output  1  with data_valid: the width counter saturated
- err_timeout  output  1  with data_valid: no hsync rise within TIMEOUT cycles; data_out holds the partial width
- locked  output  1  high once the first hsync rise is seen; low after reset or timeout

Behaviour:
- Reset:
  - All outputs are 0. data_out is 0. The FSM goes to IDLE.
  - The synchroniser, hsync_q and all counters clear.
  - rst wins over every other event in the same cycle, including mid-period; no data_valid is emitted for a period aborted by reset.
- Input conditioning:
  - pwm_s is pwm_in after SYNC_STAGES flops.
  - hsync_rise = hsync & ~hsync_q, where hsync_q is hsync registered.
  - All counting uses pwm_s; the synchroniser latency is fixed and not compensated.
- Counters:
  - width_cnt (DWIDTH bits) increments on each cycle pwm_s=1 within a period and saturates at all-ones, setting sat_f.
  - period_cnt counts cycles since the last hsync rise.
- FSM states: IDLE, LOW_PRE (period open, no pulse yet), HIGH (pulse in progress), LOW_POST (pulse ended).
  - IDLE: wait for hsync_rise, then start a period. locked<=1.
  - LOW_PRE: pwm_s=1 -> HIGH.
  - HIGH: pwm_s=0 -> LOW_POST.
  - LOW_POST: pwm_s=1 -> HIGH and set multi_f. The width keeps accumulating, so data_out is the total high time.
- Period close (hsync_rise in a non-IDLE state) — on that clock edge:
  - data_out <= width_cnt, i.e. the prior period's samples only.
  - err_trunc <= (state==HIGH); err_multi <= multi_f; err_sat <= sat_f; err_timeout <= 0; data_valid <= 1.
- Period start (any hsync_rise, including from IDLE):
  - The hsync_rise cycle's pwm_s sample belongs to the new period.
  - width_cnt <= pwm_s; state <= pwm_s ? HIGH : LOW_PRE.
  - multi_f, sat_f <= 0; period_cnt <= 1.
- Latency: data_valid is asserted in the cycle after the edge that sampled hsync_rise, for exactly one cycle.
- data_out and err_* hold their values until the next data_valid.
- Timeout: period_cnt reaching TIMEOUT in a non-IDLE state causes:
  - data_valid <= 1, err_timeout <= 1, data_out <= width_cnt, other err_* as at a normal close;
  - locked <= 0, state <= IDLE.
- A code of 0 (pwm_s never high) produces data_valid with data_out=0 and no errors.
- Back-to-back hsync rises 2 cycles apart are legal; each closes a period.

Test Plan:
- rst then hsync rise; pwm_in high for 37 cycles starting 5 cycles later; next hsync at 300 cycles -> one data_valid, data_out=37, all err_*=0, locked=1.
- pwm_in held low through two periods -> two data_valid strobes, data_out=0, no errors.
- Pulses of 10 and 15 cycles in one period -> data_out=25, err_multi=1.
- pwm_in high from cycle 250 through the next hsync rise at 300 -> err_trunc=1 and data_out=50 (approx., counting from pwm_s); the next period starts in HIGH.
- pwm_in high for 400 cycles with DWIDTH=8 -> data_out=255, err_sat=1.
- No hsync after the first rise -> after 1024 cycles data_valid with err_timeout=1 and locked=0. rst asserted mid-period with pwm high -> outputs 0, no strobe, and the next hsync relocks.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Purpose : bundles the pwm_capture measurement inputs and decoded result stream.
// Latency : n/a (signal bundle only).
// Backpressure: none; the result stream is a one-cycle strobe with no ready.
// Ports   : hsync/pwm_in into the capture block; data_out, data_valid, err_*,
//           and locked out of it. The capture block uses 'master', consumers use 'slave'.
interface pwm_capture_if #(
    parameter int DWIDTH = 8
);
    logic              hsync;
    logic              pwm_in;
    logic [DWIDTH-1:0] data_out;
    logic              data_valid;
    logic              err_multi;
    logic              err_trunc;
    logic              err_sat;
    logic              err_timeout;
    logic              locked;

    modport master (
        input  hsync, pwm_in,
        output data_out, data_valid, err_multi, err_trunc, err_sat, err_timeout, locked
    );

    modport slave (
        output hsync, pwm_in,
        input  data_out, data_valid, err_multi, err_trunc, err_sat, err_timeout, locked
    );
endinterface

// File: rtl/pwm_capture.sv
// Purpose : measures the PWM high time within each hsync period and recovers the code.
// Latency : data_valid is one cycle after the edge that samples the closing hsync rise.
// Backpressure: none; every closed or timed-out period emits one strobe.
// Ports   : clk, rst (sync, active high); bus = pwm_capture_if.master carrying
//           hsync, pwm_in (async) in and data_out/data_valid/err_*/locked out.
module pwm_capture #(
    parameter int DWIDTH      = 8,
    parameter int SYNC_STAGES = 2,    // 2..3
    parameter int TIMEOUT     = 1024  // must exceed 2**DWIDTH
) (
    input  logic          clk,
    input  logic          rst,
    pwm_capture_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOW_PRE, HIGH, LOW_POST} state_t;

    localparam int                PCW  = $clog2(TIMEOUT + 1);
    localparam logic [DWIDTH-1:0] WMAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hsync_q, hsync_d;
    state_t                 state_q, state_d;
    logic [DWIDTH-1:0]      width_cnt_q, width_cnt_d;
    logic                   multi_f_q, multi_f_d;
    logic                   sat_f_q, sat_f_d;
    logic [PCW-1:0]         period_cnt_q, period_cnt_d;
    logic [DWIDTH-1:0]      data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   err_multi_q, err_multi_d;
    logic                   err_trunc_q, err_trunc_d;
    logic                   err_sat_q, err_sat_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   locked_q, locked_d;

    logic pwm_s;
    logic hsync_rise;
    logic timeout;
    logic close;

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        hsync_d       = bus.hsync;
        pwm_s         = sync_q[SYNC_STAGES-1];
        hsync_rise    = bus.hsync & ~hsync_q;
        timeout       = (state_q != IDLE) && (period_cnt_q == PCW'(TIMEOUT));
        // A rise closes an open period; a timeout closes it only if no rise competes.
        close         = (state_q != IDLE) && (hsync_rise || timeout);

        state_d       = state_q;
        width_cnt_d   = width_cnt_q;
        multi_f_d     = multi_f_q;
        sat_f_d       = sat_f_q;
        period_cnt_d  = period_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        err_multi_d   = err_multi_q;
        err_trunc_d   = err_trunc_q;
        err_sat_d     = err_sat_q;
        err_timeout_d = err_timeout_q;
        locked_d      = locked_q;

        // Report uses the counters as they stood before this cycle's sample,
        // which belongs to the next period.
        if (close) begin
            data_out_d    = width_cnt_q;
            err_trunc_d   = (state_q == HIGH);
            err_multi_d   = multi_f_q;
            err_sat_d     = sat_f_q;
            err_timeout_d = ~hsync_rise;
            data_valid_d  = 1'b1;
        end

        if (hsync_rise) begin
            width_cnt_d  = {{(DWIDTH-1){1'b0}}, pwm_s};
            state_d      = pwm_s ? HIGH : LOW_PRE;
            multi_f_d    = 1'b0;
            sat_f_d      = 1'b0;
            period_cnt_d = PCW'(1);
            locked_d     = 1'b1;
        end else if (timeout) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else if (state_q != IDLE) begin
            period_cnt_d = period_cnt_q + PCW'(1);
            if (pwm_s) begin
                if (width_cnt_q == WMAX) sat_f_d = 1'b1;
                else                     width_cnt_d = width_cnt_q + DWIDTH'(1);
            end
            case (state_q)
                LOW_PRE:  if (pwm_s)  state_d = HIGH;
                HIGH:     if (!pwm_s) state_d = LOW_POST;
                LOW_POST: if (pwm_s) begin
                    state_d   = HIGH;
                    multi_f_d = 1'b1;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            hsync_q       <= 1'b0;
            state_q       <= IDLE;
            width_cnt_q   <= '0;
            multi_f_q     <= 1'b0;
            sat_f_q       <= 1'b0;
            period_cnt_q  <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            err_multi_q   <= 1'b0;
            err_trunc_q   <= 1'b0;
            err_sat_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            hsync_q       <= hsync_d;
            state_q       <= state_d;
            width_cnt_q   <= width_cnt_d;
            multi_f_q     <= multi_f_d;
            sat_f_q       <= sat_f_d;
            period_cnt_q  <= period_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            err_multi_q   <= err_multi_d;
            err_trunc_q   <= err_trunc_d;
            err_sat_q     <= err_sat_d;
            err_timeout_q <= err_timeout_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.err_multi   = err_multi_q;
    assign bus.err_trunc   = err_trunc_q;
    assign bus.err_sat     = err_sat_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.locked      = locked_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Purpose : exercises pwm_capture with directed and random hsync/pwm traces.
// Latency : strobes expected one cycle after the closing edge.
// Backpressure: none.
module tb_pwm_capture;
    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TO   = 1024;
    localparam int MAXW = (1 << DW) - 1;

    typedef logic [DW+3:0] rec_t;  // {timeout, sat, trunc, multi, width}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_capture_if #(.DWIDTH(DW)) bus ();
    pwm_capture #(.DWIDTH(DW), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   npass = 0;
    int   ntot  = 0;
    int   cyc   = 0;
    rec_t exp_q[$], obs_q[$];
    int   exp_t[$], obs_t[$];

    // Reference model: a period is the run of pwm samples between two hsync rises;
    // width is the number of high samples, pulses the number of high runs.
    bit   m_hist[$];
    bit   m_prev, m_open, m_last, m_locked;
    int   m_cnt, m_pulses, m_tcnt;

    always @(negedge clk) begin
        if (bus.data_valid) begin
            obs_q.push_back({bus.err_timeout, bus.err_sat, bus.err_trunc, bus.err_multi, bus.data_out});
            obs_t.push_back(cyc);
        end
    end

    task automatic push_exp(input bit to);
        exp_q.push_back({to, (m_cnt > MAXW), m_last, (m_pulses > 1), DW'((m_cnt > MAXW) ? MAXW : m_cnt)});
        exp_t.push_back(cyc);
    endtask

    task automatic step(input logic r, input logic hs, input logic pw);
        bit s, rise;
        rst        = r;
        bus.hsync  = hs;
        bus.pwm_in = pw;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_hist.delete();
            m_prev = 0; m_open = 0; m_locked = 0;
        end else begin
            m_hist.push_back(pw);
            s = (m_hist.size() > SYNC) ? m_hist[m_hist.size()-1-SYNC] : 1'b0;
            if (m_hist.size() > SYNC + 1) void'(m_hist.pop_front());
            rise   = hs && !m_prev;
            m_prev = hs;
            if (rise) begin
                if (m_open) push_exp(1'b0);
                m_open = 1; m_cnt = s; m_pulses = s; m_last = s; m_tcnt = 1; m_locked = 1;
            end else if (m_open) begin
                if (m_tcnt == TO) begin
                    push_exp(1'b1);
                    m_open = 0; m_locked = 0;
                end else begin
                    if (s && !m_last) m_pulses++;
                    m_cnt += s;
                    m_last = s;
                    m_tcnt++;
                end
            end
        end
        #1;
    endtask

    task automatic start_test();
        step(1, 0, 0);
        step(1, 0, 0);
        exp_q.delete(); obs_q.delete(); exp_t.delete(); obs_t.delete();
    endtask

    task automatic test_reset();
        step(1, 1, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        ntot++;
        if ({bus.data_out, bus.data_valid, bus.err_multi, bus.err_trunc, bus.err_sat, bus.err_timeout, bus.locked} !== '0)
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b%b want all zero", bus.data_out, bus.data_valid,
                     bus.err_multi, bus.err_trunc, bus.err_sat, bus.err_timeout, bus.locked);
        else npass++;
    endtask

    task automatic test_basic();
        start_test();
        for (int i = 0; i < 310; i++) step(0, (i < 4) || (i >= 300 && i < 304), (i >= 5 && i < 42));
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL basic_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() != 1 || obs_q[0] !== rec_t'(12'h025)) $display("FAIL basic_width37: got %h want 025", obs_q[0]);
        else npass++;
        ntot++;
        if (bus.locked !== 1'b1) $display("FAIL basic_locked: got %b want 1", bus.locked);
        else npass++;
    endtask

    task automatic test_zero();
        start_test();
        for (int i = 0; i < 610; i++) step(0, (i % 300) < 4, 0);
        step(0, 0, 0);
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL zero_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL zero_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() != 2 || obs_q[1] !== '0) $display("FAIL zero_value: got %0d strobes, last %h want 2, 000", obs_q.size(), obs_q[1]);
        else npass++;
    endtask

    task automatic test_multi();
        start_test();
        for (int i = 0; i < 205; i++) step(0, (i < 4) || (i >= 200), (i >= 20 && i < 30) || (i >= 50 && i < 65));
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL multi_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL multi_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() < 1 || obs_q[0] !== rec_t'(12'h119)) $display("FAIL multi_width25: got %h want 119", obs_q[0]);
        else npass++;
    endtask

    task automatic test_trunc();
        start_test();
        for (int i = 0; i < 605; i++) step(0, (i % 300) < 4, (i >= 250 && i < 350));
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL trunc_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL trunc_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() != 2 || obs_q[0][DW+1] !== 1'b1 || obs_q[1][DW+2:DW] !== 3'b000)
            $display("FAIL trunc_flags: got %h,%h want trunc then clean single pulse", obs_q[0], obs_q[1]);
        else npass++;
    endtask

    task automatic test_sat();
        start_test();
        for (int i = 0; i < 505; i++) step(0, (i < 4) || (i >= 500), (i >= 10 && i < 410));
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL sat_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL sat_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() < 1 || obs_q[0] !== rec_t'(12'h4FF)) $display("FAIL sat_value: got %h want 4ff", obs_q[0]);
        else npass++;
    endtask

    task automatic test_timeout();
        start_test();
        for (int i = 0; i < 1100; i++) step(0, i < 4, (i >= 100 && i < 140));
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL timeout_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() != 1 || obs_q[0] !== rec_t'(12'h828) || bus.locked !== 1'b0)
            $display("FAIL timeout_value: got %h locked %b want 828 locked 0", obs_q[0], bus.locked);
        else npass++;
    endtask

    task automatic test_reset_mid();
        start_test();
        for (int i = 0; i < 305; i++) begin
            step(i == 100 || i == 101, (i < 4) || i == 100 || i == 101 || (i >= 150 && i < 154) || (i >= 300),
                 (i >= 10 && i < 102) || (i >= 200 && i < 220));
            if (i == 101) begin
                ntot++;
                if ({bus.data_out, bus.data_valid, bus.err_multi, bus.err_trunc, bus.err_sat, bus.err_timeout, bus.locked} !== '0)
                    $display("FAIL rstmid_outputs: got %h/%b/%b want zero", bus.data_out, bus.data_valid, bus.locked);
                else npass++;
            end
            if (i == 120) begin
                ntot++;
                if (bus.locked !== 1'b0) $display("FAIL rstmid_unlocked: got %b want 0", bus.locked);
                else npass++;
            end
        end
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL rstmid_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() != 1 || obs_q[0] !== rec_t'(12'h014) || bus.locked !== 1'b1)
            $display("FAIL rstmid_relock: got %0d strobes %h locked %b want 1, 014, 1", obs_q.size(), obs_q[0], bus.locked);
        else npass++;
    endtask

    task automatic test_back_to_back();
        start_test();
        for (int i = 0; i < 12; i++) step(0, (i % 2 == 0) && (i < 8), 1);
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL b2b_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (obs_q.size() != 3 || obs_t[1] - obs_t[0] != 2 || obs_q[2] !== rec_t'(12'h202))
            $display("FAIL b2b_spacing: got %0d strobes, gap %0d, last %h want 3, 2, 202",
                     obs_q.size(), obs_t[1] - obs_t[0], obs_q[2]);
        else npass++;
    endtask

    task automatic test_random();
        int   len, hsw;
        logic pw;
        start_test();
        pw = 1'b0;
        for (int p = 0; p < 16; p++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : $urandom_range(20, 240);
            hsw = $urandom_range(1, (len - 1 > 3) ? 3 : len - 1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 11) == 0) pw = ~pw;
                step(0, i < hsw, pw);
            end
        end
        step(0, 1, pw);
        step(0, 0, 0);
        step(0, 0, 0);
        ntot++;
        if (obs_q.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else npass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            ntot++;
            if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i])
                $display("FAIL random_strobe%0d: got %h@%0d want %h@%0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
            else npass++;
        end
        ntot++;
        if (bus.locked !== logic'(m_locked)) $display("FAIL random_locked: got %b want %b", bus.locked, m_locked);
        else npass++;
    endtask

    initial begin
        rst        = 1'b1;
        bus.hsync  = 1'b0;
        bus.pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_multi();
        test_trunc();
        test_sat();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
